down_timer: RTL and testbench

Preset down-counter timer for the board's two seven-segment digits. It loads a preset (5–60 s) selected by the 4-bit DIP switch, decrements once per second, and supports pause/resume, abort and an end-of-count alarm. It is the counting-down counterpart to the existing count-up timer and drives the same two 9-bit segment buses, using the same digit encoding. Inputs `start` and `hold` arrive already debounced and synchronized to `clk`.

---
 rtl/down_timer.sv | 152 +++++++++++++++
 tb/tb_down_timer.sv | 134 +++++++++++++
 2 files changed

// File: rtl/down_timer.sv
// rtl/down_timer.sv - preset seven-segment down-counter timer with pause, abort and alarm
// Optional DOWN_TIMER_BLINK_EN makes the "00" display blink at 1 Hz while the alarm is up.
`timescale 1ns/1ps
module down_timer #(
  parameter int TICK_CYCLES = 12000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       hold,
  input  logic [3:0] sw,
  output logic [8:0] seg_led_1,
  output logic [8:0] seg_led_2,
  output logic       done,
  output logic       led
);

  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
`ifdef DOWN_TIMER_BLINK_EN
  localparam logic [TW-1:0] TICK_HALF = TW'(TICK_CYCLES / 2);
`endif

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t        state, state_next;
  logic          start_q, hold_q;
  logic          start_edge, hold_edge;
  logic [5:0]    count, preset;
  logic [5:0]    tens, ones;
  logic [TW-1:0] tick;
  logic          tick_wrap;

  assign start_edge = start & ~start_q;
  assign hold_edge  = hold & ~hold_q;
  assign tick_wrap  = (tick == TICK_LAST);
  assign tens       = count / 6'd10;
  assign ones       = count % 6'd10;

  function automatic logic [8:0] seg7(input logic [5:0] d);
    case (d)
      6'd0:    seg7 = 9'h03f;
      6'd1:    seg7 = 9'h006;
      6'd2:    seg7 = 9'h05b;
      6'd3:    seg7 = 9'h04f;
      6'd4:    seg7 = 9'h066;
      6'd5:    seg7 = 9'h06d;
      6'd6:    seg7 = 9'h07d;
      6'd7:    seg7 = 9'h007;
      6'd8:    seg7 = 9'h07f;
      6'd9:    seg7 = 9'h06f;
      default: seg7 = 9'h03f;
    endcase
  endfunction

  always_comb begin
    preset = 6'd24;
    case (sw)
      4'b0000: preset = 6'd5;
      4'b0001: preset = 6'd10;
      4'b0010: preset = 6'd20;
      4'b0011: preset = 6'd30;
      4'b0100: preset = 6'd35;
      4'b0101: preset = 6'd40;
      4'b0110: preset = 6'd50;
      4'b0111: preset = 6'd60;
      default: preset = 6'd24;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // start outranks hold everywhere, so a simultaneous pair behaves as a plain abort
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (start_edge) state_next = RUN;
      RUN: begin
        if (start_edge)                     state_next = IDLE;
        else if (hold_edge)                 state_next = PAUSE;
        else if (tick_wrap && count == 6'd1) state_next = DONE;
      end
      PAUSE: begin
        if (start_edge)     state_next = IDLE;
        else if (hold_edge) state_next = RUN;
      end
      DONE:  if (start_edge) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A hold edge in RUN freezes the tick on that same edge, keeping the phase for resume
  always_ff @(posedge clk) begin
    if (rst) begin
      start_q <= 1'b0;
      hold_q  <= 1'b0;
      count   <= 6'd0;
      tick    <= '0;
    end else begin
      start_q <= start;
      hold_q  <= hold;
      case (state)
        IDLE: begin
          count <= preset;
          tick  <= '0;
        end
        RUN: begin
          if (start_edge) begin
            tick <= '0;
          end else if (!hold_edge) begin
            tick <= tick_wrap ? '0 : tick + TW'(1);
            if (tick_wrap) count <= count - 6'd1;
          end
        end
        PAUSE: if (start_edge) tick <= '0;
        DONE: begin
          count <= 6'd0;
`ifdef DOWN_TIMER_BLINK_EN
          tick  <= (start_edge || tick_wrap) ? '0 : tick + TW'(1);
`else
          tick  <= '0;
`endif
        end
        default: tick <= '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_led_1 <= 9'h03f;
      seg_led_2 <= 9'h03f;
      done      <= 1'b0;
      led       <= 1'b0;
    end else begin
      done      <= (state == DONE);
      led       <= (state == PAUSE);
      seg_led_1 <= seg7(ones);
      seg_led_2 <= seg7(tens);
`ifdef DOWN_TIMER_BLINK_EN
      if (state == DONE && tick >= TICK_HALF) begin
        seg_led_1 <= 9'h000;
        seg_led_2 <= 9'h000;
      end
`endif
    end
  end

endmodule

// File: tb/tb_down_timer.sv
// tb/tb_down_timer.sv - directed self-checking bench for down_timer (TICK_CYCLES=10)
`timescale 1ns/1ps
module tb_down_timer;

  logic       clk = 1'b0;
  logic       rst, start, hold;
  logic [3:0] sw;
  logic [8:0] seg_led_1, seg_led_2;
  logic       done, led;
  int         tests = 0;
  int         fails = 0;

  down_timer #(.TICK_CYCLES(10)) dut (
    .clk(clk), .rst(rst), .start(start), .hold(hold), .sw(sw),
    .seg_led_1(seg_led_1), .seg_led_2(seg_led_2), .done(done), .led(led)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_disp(input string tag, input logic [8:0] tens_exp, input logic [8:0] ones_exp);
    check({tag, ".tens"}, seg_led_2, tens_exp);
    check({tag, ".ones"}, seg_led_1, ones_exp);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; hold = 1'b0; sw = 4'b0000;
    tick(3);
    check_disp("reset_seg", 9'h03f, 9'h03f);
    check("reset_done", {8'd0, done}, 9'd0);
    check("reset_led", {8'd0, led}, 9'd0);

    // release: preset loads one edge later, display a further edge later
    rst = 1'b0;
    tick(1);
    check("lag_ones", seg_led_1, 9'h03f);
    tick(1);
    check_disp("preset05", 9'h03f, 9'h06d);
    check("idle_done", {8'd0, done}, 9'd0);

    // sw=0000 run to completion
    start = 1'b1; tick(1); start = 1'b0;
    tick(11);
    check_disp("run04", 9'h03f, 9'h066);
    tick(39);
    check("done_not_yet", {8'd0, done}, 9'd0);
    tick(1);
    check("done_high", {8'd0, done}, 9'd1);
    check_disp("done00", 9'h03f, 9'h03f);
    tick(5);
`ifdef DOWN_TIMER_BLINK_EN
    check_disp("blink_off", 9'h000, 9'h000);
`else
    check_disp("steady_a", 9'h03f, 9'h03f);
`endif
    tick(5);
    check_disp("blink_on", 9'h03f, 9'h03f);
    hold = 1'b1; tick(1); hold = 1'b0;
    tick(2);
    check("done_hold_ign", {8'd0, done}, 9'd1);
    check("done_hold_led", {8'd0, led}, 9'd0);
    start = 1'b1; tick(1); start = 1'b0;
    tick(3);
    check("done_cleared", {8'd0, done}, 9'd0);
    check_disp("reload05", 9'h03f, 9'h06d);

    // sw=0010: pause at 17 with tick phase 3, resume
    sw = 4'b0010;
    tick(2);
    check_disp("preset20", 9'h05b, 9'h03f);
    start = 1'b1; tick(1); start = 1'b0;
    tick(33);
    hold = 1'b1; tick(1); hold = 1'b0;
    tick(1);
    check("pause_led", {8'd0, led}, 9'd1);
    check_disp("pause17", 9'h006, 9'h007);
    tick(100);
    check_disp("frozen17", 9'h006, 9'h007);
    hold = 1'b1; tick(1); hold = 1'b0;
    tick(7);
    check("resume_led", {8'd0, led}, 9'd0);
    check_disp("resume17", 9'h006, 9'h007);
    tick(1);
    check_disp("resume16", 9'h006, 9'h07d);

    // simultaneous start and hold: abort wins
    start = 1'b1; hold = 1'b1; tick(1); start = 1'b0; hold = 1'b0;
    tick(2);
    check("abort_led", {8'd0, led}, 9'd0);
    check("abort_done", {8'd0, done}, 9'd0);
    check_disp("abort20", 9'h05b, 9'h03f);

    // sw=1111 preset 24, sw ignored while running
    sw = 4'b1111;
    tick(2);
    check_disp("preset24", 9'h05b, 9'h066);
    start = 1'b1; tick(1); start = 1'b0;
    sw = 4'b0000;
    tick(11);
    check_disp("run23", 9'h05b, 9'h04f);
    tick(139);
    check_disp("run10", 9'h006, 9'h03f);
    hold = 1'b1; tick(1); hold = 1'b0;
    tick(1);
    check("pause9_led", {8'd0, led}, 9'd1);
    check_disp("pause09", 9'h03f, 9'h06f);

    // reset mid-count returns outputs to reset values on the next edge
    rst = 1'b1;
    tick(1);
    check("rst_led", {8'd0, led}, 9'd0);
    check("rst_done", {8'd0, done}, 9'd0);
    check_disp("rst_seg", 9'h03f, 9'h03f);
    rst = 1'b0;
    tick(2);
    check_disp("rst_reload05", 9'h03f, 9'h06d);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
